// File: rtl/ni_rx_dma.sv
// Receive-side DMA: takes flits from the router's local port and writes each packet
// (header first, then payload) into the shared RAM through port B.
module ni_rx_dma #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        arm,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [LEN_WIDTH:0]          capacity,
  input  logic [MEMORY_BUS_WIDTH-1:0] rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data,
  output logic [3:0]                  mem_wb,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [LEN_WIDTH:0]          words_stored
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FINISH} state_e;

  localparam logic [LEN_WIDTH-1:0] LenOne   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]   WordsOne = (LEN_WIDTH + 1)'(1);

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         base_q, base_d;
  logic [LEN_WIDTH:0]            cap_q, cap_d;
  logic [LEN_WIDTH-1:0]          len_q, len_d;
  logic [LEN_WIDTH-1:0]          k_q, k_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [MEMORY_BUS_WIDTH-1:0]   data_q, data_d;
  logic [3:0]                    wb_q, wb_d;
  logic                          ovf_q, ovf_d;
  logic [LEN_WIDTH:0]            words_q, words_d;
  logic [LEN_WIDTH-1:0]          kNext;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      cap_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wb_q    <= '0;
      ovf_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cap_q   <= cap_d;
      len_q   <= len_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wb_q    <= wb_d;
      ovf_q   <= ovf_d;
      words_q <= words_d;
    end
  end

  // Flits beyond the buffer are still consumed so the router never stalls; they just don't write.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cap_d   = cap_q;
    len_d   = len_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wb_d    = 4'h0;
    ovf_d   = ovf_q;
    words_d = words_q;
    kNext   = k_q + LenOne;
    case (state_q)
      IDLE: begin
        if (arm) begin
          base_d  = base_addr;
          cap_d   = capacity;
          ovf_d   = 1'b0;
          words_d = '0;
          k_d     = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (rx_valid) begin
          len_d = rx_data[LEN_WIDTH-1:0];
          k_d   = '0;
          if (cap_q != '0) begin
            addr_d  = base_q;
            data_d  = rx_data;
            wb_d    = 4'hF;
            words_d = WordsOne;
          end else begin
            ovf_d   = 1'b1;
            words_d = '0;
          end
          state_d = (rx_data[LEN_WIDTH-1:0] == '0) ? FINISH : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          k_d = kNext;
          if ({1'b0, kNext} < cap_q) begin
            addr_d  = base_q + ADDR_WIDTH'(kNext);
            data_d  = rx_data;
            wb_d    = 4'hF;
            words_d = words_q + WordsOne;
          end else begin
            ovf_d = 1'b1;
          end
          if (kNext == len_q) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_ready     = (state_q == HEADER) || (state_q == PAYLOAD);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_wb       = wb_q;
  assign overflow     = ovf_q;
  assign words_stored = words_q;

endmodule

// File: tb/tb_ni_rx_dma.sv
// Directed bench for ni_rx_dma: a port-B RAM model plus hand-computed expectations
// for each test-plan scenario.
module tb_ni_rx_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm;
  logic [15:0] base_addr;
  logic [16:0] capacity;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_wb;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [16:0] words_stored;

  logic [31:0] ram [0:65535];
  int checks = 0;
  int errors = 0;
  int badWrites = 0;

  ni_rx_dma dut (
    .clock(clock), .reset(reset), .arm(arm), .base_addr(base_addr), .capacity(capacity),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wb(mem_wb),
    .busy(busy), .done(done), .overflow(overflow), .words_stored(words_stored)
  );

  always #5 clock = ~clock;

  // Port B of the RAM commits on the edge after the strobe appears.
  always @(posedge clock) begin
    if (mem_wb == 4'hF) ram[mem_addr] <= mem_data;
    if (mem_wb != 4'h0 && !busy) badWrites <= badWrites + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic armDma(input logic [15:0] base, input logic [16:0] cap);
    arm = 1'b1; base_addr = base; capacity = cap;
    tick();
    arm = 1'b0;
  endtask

  task automatic sendFlit(input logic [31:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; base_addr = '0; capacity = '0; rx_data = '0; rx_valid = 1'b0;
    ram[16'h0303] = 32'hDEADBEEF;
    ram[16'h0400] = 32'h11111111;
    ram[16'h0202] = 32'h12345678;
    tick(); tick();
    check("rst_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_wb", {28'b0, mem_wb}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_words", {15'b0, words_stored}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic packet
    armDma(16'h0100, 17'd8);
    check("b_busy", {31'b0, busy}, 32'd1);
    check("b_ready", {31'b0, rx_ready}, 32'd1);
    sendFlit(32'h3);
    check("b_hdr_wb", {28'b0, mem_wb}, 32'hF);
    check("b_hdr_addr", {16'b0, mem_addr}, 32'h0100);
    sendFlit(32'hA1);
    sendFlit(32'hA2);
    check("b_done_early", {31'b0, done}, 32'd0);
    sendFlit(32'hA3);
    check("b_done", {31'b0, done}, 32'd1);
    check("b_last_wb", {28'b0, mem_wb}, 32'hF);
    check("b_last_addr", {16'b0, mem_addr}, 32'h0103);
    check("b_words", {15'b0, words_stored}, 32'd4);
    check("b_ovf", {31'b0, overflow}, 32'd0);
    tick();
    check("b_done_off", {31'b0, done}, 32'd0);
    check("b_idle", {31'b0, busy}, 32'd0);
    check("b_wb_off", {28'b0, mem_wb}, 32'd0);
    check("b_ram0", ram[16'h0100], 32'h3);
    check("b_ram1", ram[16'h0101], 32'hA1);
    check("b_ram2", ram[16'h0102], 32'hA2);
    check("b_ram3", ram[16'h0103], 32'hA3);

    // Overflow: capacity 3, five payload flits
    armDma(16'h0300, 17'd3);
    sendFlit(32'h5);
    sendFlit(32'hB1);
    sendFlit(32'hB2);
    check("o_wb_k2", {28'b0, mem_wb}, 32'hF);
    sendFlit(32'hB3);
    check("o_wb_k3", {28'b0, mem_wb}, 32'h0);
    check("o_ovf_set", {31'b0, overflow}, 32'd1);
    sendFlit(32'hB4);
    check("o_ready", {31'b0, rx_ready}, 32'd1);
    sendFlit(32'hB5);
    check("o_done", {31'b0, done}, 32'd1);
    check("o_words", {15'b0, words_stored}, 32'd3);
    tick();
    check("o_ram0", ram[16'h0300], 32'h5);
    check("o_ram2", ram[16'h0302], 32'hB2);
    check("o_ram3", ram[16'h0303], 32'hDEADBEEF);

    // Zero length; arm also clears the sticky overflow
    armDma(16'h0400, 17'd4);
    check("z_ovf_clr", {31'b0, overflow}, 32'd0);
    check("z_words_clr", {15'b0, words_stored}, 32'd0);
    sendFlit(32'h0);
    check("z_wb", {28'b0, mem_wb}, 32'hF);
    check("z_done", {31'b0, done}, 32'd1);
    check("z_words", {15'b0, words_stored}, 32'd1);
    tick();
    check("z_ram", ram[16'h0400], 32'h0);

    // Bubbles and address wrap
    armDma(16'hFFFE, 17'd8);
    sendFlit(32'h3);
    check("w_addr0", {16'b0, mem_addr}, 32'hFFFE);
    tick();
    check("w_bub0", {28'b0, mem_wb}, 32'h0);
    sendFlit(32'hC1);
    check("w_addr1", {16'b0, mem_addr}, 32'hFFFF);
    tick();
    check("w_bub1", {28'b0, mem_wb}, 32'h0);
    sendFlit(32'hC2);
    check("w_addr2", {16'b0, mem_addr}, 32'h0000);
    tick();
    check("w_bub2", {28'b0, mem_wb}, 32'h0);
    check("w_bub2_done", {31'b0, done}, 32'd0);
    sendFlit(32'hC3);
    check("w_addr3", {16'b0, mem_addr}, 32'h0001);
    check("w_done", {31'b0, done}, 32'd1);
    tick();
    check("w_ram_ffff", ram[16'hFFFF], 32'hC1);
    check("w_ram_0", ram[16'h0000], 32'hC2);
    check("w_ram_1", ram[16'h0001], 32'hC3);
    check("w_words", {15'b0, words_stored}, 32'd4);

    // Reset mid-packet, then a fresh packet
    armDma(16'h0500, 17'd8);
    sendFlit(32'h4);
    sendFlit(32'hD1);
    sendFlit(32'hD2);
    reset = 1'b0;
    tick();
    check("r_busy", {31'b0, busy}, 32'd0);
    check("r_ready", {31'b0, rx_ready}, 32'd0);
    check("r_wb", {28'b0, mem_wb}, 32'd0);
    check("r_addr", {16'b0, mem_addr}, 32'd0);
    check("r_data", mem_data, 32'd0);
    check("r_done", {31'b0, done}, 32'd0);
    check("r_words", {15'b0, words_stored}, 32'd0);
    reset = 1'b1;
    tick();
    check("r_kept", ram[16'h0502], 32'hD2);
    armDma(16'h0600, 17'd8);
    sendFlit(32'h1);
    sendFlit(32'hE1);
    check("r2_done", {31'b0, done}, 32'd1);
    check("r2_words", {15'b0, words_stored}, 32'd2);
    tick();
    check("r2_ram0", ram[16'h0600], 32'h1);
    check("r2_ram1", ram[16'h0601], 32'hE1);

    // Arm while busy (PAYLOAD and FINISH) is ignored
    armDma(16'h0700, 17'd8);
    sendFlit(32'h2);
    sendFlit(32'hF1);
    arm = 1'b1; base_addr = 16'h0200;
    sendFlit(32'hF2);
    check("a_addr", {16'b0, mem_addr}, 32'h0702);
    check("a_done", {31'b0, done}, 32'd1);
    tick();
    arm = 1'b0;
    check("a_fin_arm", {31'b0, busy}, 32'd0);
    tick();
    check("a_ram", ram[16'h0702], 32'hF2);
    check("a_other", ram[16'h0202], 32'h12345678);
    check("idle_writes", badWrites, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
